// File: rtl/ymux2_arbiter.sv
// ymux2_arbiter: round-robin burst arbiter that owns the 2:1 mux select; ARB_TIMEOUT_EN adds a stall-release timer
module ymux2_arbiter #(
    parameter int W       = 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy,
    output logic [CNT_W-1:0] burst_cnt,
    output logic             timeout
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t           state_q, state_d;
    logic             sel_q, sel_d, last_winner_q, last_winner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             own, cur_valid, cur_last, other_valid, beat, done, rel, win;

    assign own         = state_q != IDLE;
    assign cur_valid   = sel_q ? req1_valid : req0_valid;
    assign cur_last    = sel_q ? req1_last : req0_last;
    assign other_valid = sel_q ? req0_valid : req1_valid;
    assign beat        = own & cur_valid & out_ready;
    assign done        = beat & cur_last;
    assign rel         = done | timeout;
    assign win         = (req0_valid & req1_valid) ? ~last_winner_q : req1_valid;

    assign out_valid  = own & cur_valid;
    assign out_data   = sel_q ? req1_data : req0_data;
    assign out_last   = own & cur_last;
    assign req0_ready = (state_q == OWN0) & out_ready;
    assign req1_ready = (state_q == OWN1) & out_ready;
    assign sel        = sel_q;
    assign busy       = own;
    assign burst_cnt  = burst_cnt_q;

`ifdef ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_q, stall_d;

    assign timeout = own & ~beat & (stall_q == SW'(TIMEOUT - 1));

    // stall count restarts on every beat, every grant change and while idle
    always_comb stall_d = (!own || beat || timeout) ? '0 : stall_q + 1'b1;

    // stall counter register
    always_ff @(posedge clk) stall_q <= !rst_n ? '0 : stall_d;
`else
    assign timeout = TIMEOUT < 0;
`endif

    // grant, round-robin history and completed-burst count
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        last_winner_d = last_winner_q;
        burst_cnt_d   = burst_cnt_q + CNT_W'(done);
        if (!own) begin
            if (req0_valid | req1_valid) begin
                state_d = win ? OWN1 : OWN0;
                sel_d   = win;
            end
        end else if (rel) begin
            last_winner_d = sel_q;
            state_d       = other_valid ? (sel_q ? OWN0 : OWN1) : IDLE;
            sel_d         = other_valid ? ~sel_q : sel_q;
        end
    end

    // state registers; last_winner resets to 1 so req0 wins the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_q         <= 1'b0;
            last_winner_q <= 1'b1;
            burst_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            last_winner_q <= last_winner_d;
            burst_cnt_q   <= burst_cnt_d;
        end
    end
endmodule

// File: doc/ymux2_arbiter.md
Name: ymux2_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 2:1 mux datapath (yMux2-style, W-bit).
- Two requesters compete for one downstream port; the block owns the mux select.
- Holds the grant for a whole burst (beats up to and including the beat with last=1).
- Uses a valid/ready handshake on every interface. Sits between producer units and a single shared consumer bus.

Parameters:
W, 2, data width of each requester and of the muxed output
CNT_W, 8, width of the completed-burst counter
TIMEOUT, 16, stall cycles before forced release (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk
req0_valid  in  1  requester 0 has a beat
req0_data  in  W  requester 0 beat data
req0_last  in  1  final beat of requester 0 burst
req0_ready  out  1  requester 0 beat accepted this cycle
req1_valid, req1_data, req1_last, req1_ready  same as req0, for requester 1
out_valid  out  1  muxed beat valid
out_data  out  W  muxed data (mux output, select = sel)
out_last  out  1  muxed last
out_ready  in  1  consumer accepts beat
sel  out  1  registered mux select (0 = req0, 1 = req1)
busy  out  1  1 when in OWN0 or OWN1
burst_cnt  out  CNT_W  completed bursts, wraps
timeout  out  1  one-cycle forced-release pulse

Behaviour:
- State machine (registered): IDLE, OWN0, OWN1. Registered state: sel, last_winner, burst_cnt.
- Reset (rst_n=0 at an edge): state=IDLE, sel=0, last_winner=1 (req0 wins first tie), burst_cnt=0, timeout=0.
- Reset mid-burst has the same effect. The partial burst is abandoned with no count.
- IDLE outputs: out_valid=0, both ready=0, busy=0. Data never passes in IDLE.
- IDLE transitions:
  - Only reqX_valid set: go to OWNX and set sel=X on the same edge.
  - Both valid: winner is the requester other than last_winner.
  - Arbitration latency is 1 cycle from valid to first possible beat.
- OWNX outputs (combinational from registered state):
  - out_valid=reqX_valid, out_data=reqX_data, out_last=reqX_last.
  - reqX_ready=out_ready; the other ready=0; busy=1.
- Beat definition: reqX_valid & out_ready.
- Beat with reqX_last=1 ends the burst:
  - last_winner=X and burst_cnt+1 (wraps at 2^CNT_W-1 to 0).
  - Next state: OWN(other) with sel flipped if the other valid is high on that edge (back-to-back, no IDLE bubble). Otherwise IDLE, with sel unchanged.
- reqX_valid low mid-burst: grant is held and out_valid=0. Other requester waits regardless of its valid.
- sel changes only on grant transitions; it is never combinational from the valids.
- out_ready high while out_valid low: no beat, no state change.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined: a stall counter (clog2(TIMEOUT+1) bits) clears on every beat and on grant change, and increments each OWNX cycle without a beat.
  - When it reaches TIMEOUT, the grant is released as if last: last_winner=X, burst_cnt not incremented, next state chosen as on a normal release.
  - timeout=1 for exactly that cycle.
- Undefined: no counter; grant held indefinitely; timeout tied 0.

Test Plan:
- Reset, then only req0_valid=1 with data=2'b10, last=1, out_ready=1: cycle 1 sel=0, busy=1; cycle 2 beat out_data=10, burst_cnt=1, state IDLE.
- Both valid from IDLE after reset: req0 granted first; on req0 last beat with req1 still valid, next cycle OWN1, sel=1, no idle cycle; burst_cnt=2 after req1 last beat.
- Three-beat req1 burst, out_ready toggling 1,0,1,1 and req0 valid throughout: req0_ready stays 0 until req1 last accepted; out_data tracks req1_data each beat.
- burst_cnt wrap: 256 single-beat bursts -> burst_cnt returns to 0.
- rst_n=0 for one edge during OWN1 mid-burst: next cycle state IDLE, sel=0, burst_cnt=0, all readies 0.
- ARB_TIMEOUT_EN defined, TIMEOUT=16: req0 granted, out_ready=0 for 16 cycles -> timeout pulses once, grant moves to valid req1, burst_cnt unchanged; undefined: grant held and timeout stays 0.
